// File: rtl/hdmi_pll_reset_seq.sv
// hdmi_pll_reset_seq
//   Reset/lock sequencer for the HDMI 5x serial-clock PLL, running on the
//   50 MHz reference clock. Pulses the PLL reset and waits for lock, retrying
//   on timeout. Once lock has been stable it releases the CLKDIV reset and,
//   after a settle time, the HDMI datapath reset. Loss of lock re-sequences.
// Ports
//   clkin          50 MHz reference clock
//   reset          asynchronous active-high reset
//   pll_lock       PLL lock, asynchronous to clkin (synchronized internally)
//   pll_reset      PLL reset, active-high
//   clkdiv_resetn  CLKDIV reset, active-low
//   hdmi_rst_n     HDMI datapath reset request, active-low
//   ready          high only in RUN
//   fail           high only in FAIL (terminal until reset)
//   retry_cnt      timeout retries in the current acquisition
//   relock_cnt     lock-loss events since reset, saturating at 255
module hdmi_pll_reset_seq #(
    parameter int unsigned RST_PULSE_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT       = 500000,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned DIV_SETTLE_CYCLES  = 8,
    parameter int unsigned MAX_RETRIES        = 3     // must fit retry_cnt (<= 3)
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_lock,
    output logic       pll_reset,
    output logic       clkdiv_resetn,
    output logic       hdmi_rst_n,
    output logic       ready,
    output logic       fail,
    output logic [1:0] retry_cnt,
    output logic [7:0] relock_cnt
);

    // Shared counter is sized for the longest interval it has to measure.
    localparam int unsigned MAX_A   = (RST_PULSE_CYCLES > LOCK_TIMEOUT) ? RST_PULSE_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned MAX_B   = (LOCK_STABLE_CYCLES > DIV_SETTLE_CYCLES) ? LOCK_STABLE_CYCLES : DIV_SETTLE_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(DIV_SETTLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        ST_RST,
        ST_WAIT_LOCK,
        ST_STABLE,
        ST_DIV_REL,
        ST_RUN,
        ST_LOSS,
        ST_FAIL
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [1:0]       retry_nxt;
    logic [7:0]       relock_nxt, relock_inc;
    logic             lock_meta, lock_s;
    logic             pll_reset_nxt, clkdiv_resetn_nxt, hdmi_rst_n_nxt, ready_nxt, fail_nxt;

    // Two-flop synchronizer for the asynchronous lock signal.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            lock_meta <= pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state         <= ST_RST;
            cnt           <= '0;
            retry_cnt     <= '0;
            relock_cnt    <= '0;
            pll_reset     <= 1'b1;
            clkdiv_resetn <= 1'b0;
            hdmi_rst_n    <= 1'b0;
            ready         <= 1'b0;
            fail          <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            retry_cnt     <= retry_nxt;
            relock_cnt    <= relock_nxt;
            pll_reset     <= pll_reset_nxt;
            clkdiv_resetn <= clkdiv_resetn_nxt;
            hdmi_rst_n    <= hdmi_rst_n_nxt;
            ready         <= ready_nxt;
            fail          <= fail_nxt;
        end
    end

    // Next-state, counter and output decode; outputs follow the next state so
    // they change in the same cycle as the state register.
    always_comb begin
        state_nxt  = state;
        retry_nxt  = retry_cnt;
        relock_nxt = relock_cnt;
        relock_inc = (relock_cnt == 8'hFF) ? relock_cnt : relock_cnt + 8'd1;

        case (state)
            ST_RST: begin
                if (cnt == RST_LAST) state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (lock_s) begin
                    state_nxt = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt < RETRY_LIMIT) begin
                        retry_nxt = retry_cnt + 2'd1;
                        state_nxt = ST_RST;
                    end else begin
                        state_nxt = ST_FAIL;
                    end
                end
            end
            ST_STABLE: begin
                // A glitch restarts the timeout window but is not a retry.
                if (!lock_s)                state_nxt = ST_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = ST_DIV_REL;
            end
            ST_DIV_REL: begin
                if (!lock_s) begin
                    state_nxt  = ST_LOSS;
                    relock_nxt = relock_inc;
                end else if (cnt == SETTLE_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_nxt  = ST_LOSS;
                    relock_nxt = relock_inc;
                end
            end
            ST_LOSS: state_nxt = ST_RST;
            ST_FAIL: state_nxt = ST_FAIL;
            default: state_nxt = ST_RST;
        endcase

        if (state_nxt == ST_RUN && state != ST_RUN) retry_nxt = '0;

        cnt_nxt = (state_nxt != state) ? '0 : cnt + CNT_W'(1);

        pll_reset_nxt     = (state_nxt == ST_RST) || (state_nxt == ST_FAIL);
        clkdiv_resetn_nxt = (state_nxt == ST_DIV_REL) || (state_nxt == ST_RUN);
        hdmi_rst_n_nxt    = (state_nxt == ST_RUN);
        ready_nxt         = (state_nxt == ST_RUN);
        fail_nxt          = (state_nxt == ST_FAIL);
    end

endmodule

// File: tb/tb_hdmi_pll_reset_seq.sv
// Directed bench for hdmi_pll_reset_seq with short timing parameters.
module tb_hdmi_pll_reset_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       pll_lock;
    logic       pll_reset, clkdiv_resetn, hdmi_rst_n, ready, fail;
    logic [1:0] retry_cnt;
    logic [7:0] relock_cnt;

    int total = 0;
    int bad   = 0;

    hdmi_pll_reset_seq #(
        .RST_PULSE_CYCLES  (4),
        .LOCK_TIMEOUT      (50),
        .LOCK_STABLE_CYCLES(16),
        .DIV_SETTLE_CYCLES (8),
        .MAX_RETRIES       (3)
    ) dut (
        .clkin        (clk),
        .reset        (reset),
        .pll_lock     (pll_lock),
        .pll_reset    (pll_reset),
        .clkdiv_resetn(clkdiv_resetn),
        .hdmi_rst_n   (hdmi_rst_n),
        .ready        (ready),
        .fail         (fail),
        .retry_cnt    (retry_cnt),
        .relock_cnt   (relock_cnt)
    );

    always #5 clk = ~clk;

    // Advance one clock and land 1 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for three edges; release leaves the next edge as cycle 1.
    task automatic do_reset(input logic lock_val);
        reset    = 1'b1;
        pll_lock = lock_val;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_clkdiv(input logic val, input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (clkdiv_resetn === val) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ready(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            step();
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        pll_lock = 1'b0;
        repeat (3) step();
        total++; if (pll_reset !== 1'b1)     begin bad++; $display("FAIL rst_pll_reset got=%b want=1", pll_reset); end
        total++; if (clkdiv_resetn !== 1'b0) begin bad++; $display("FAIL rst_clkdiv got=%b want=0", clkdiv_resetn); end
        total++; if (hdmi_rst_n !== 1'b0)    begin bad++; $display("FAIL rst_hdmi got=%b want=0", hdmi_rst_n); end
        total++; if (ready !== 1'b0)         begin bad++; $display("FAIL rst_ready got=%b want=0", ready); end
        total++; if (fail !== 1'b0)          begin bad++; $display("FAIL rst_fail got=%b want=0", fail); end
        total++; if (retry_cnt !== 2'd0)     begin bad++; $display("FAIL rst_retry got=%0d want=0", retry_cnt); end
        total++; if (relock_cnt !== 8'd0)    begin bad++; $display("FAIL rst_relock got=%0d want=0", relock_cnt); end
    endtask

    // Lock arrives at cycle 10: synced at 12, STABLE 13..28, DIV_REL 29..36, RUN 37.
    task automatic test_lock_sequence();
        int   clk_rise, hdmi_rise, rdy_rise;
        logic pr3, pr4;
        clk_rise = -1; hdmi_rise = -1; rdy_rise = -1; pr3 = 1'b0; pr4 = 1'b1;
        do_reset(1'b0);
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k == 3) pr3 = pll_reset;
            if (k == 4) pr4 = pll_reset;
            if (clkdiv_resetn === 1'b1 && clk_rise < 0) clk_rise = k;
            if (hdmi_rst_n === 1'b1 && hdmi_rise < 0)   hdmi_rise = k;
            if (ready === 1'b1 && rdy_rise < 0)         rdy_rise = k;
            if (k == 10) pll_lock = 1'b1;
        end
        total++; if (pr3 !== 1'b1)    begin bad++; $display("FAIL seq_pll_reset_c3 got=%b want=1", pr3); end
        total++; if (pr4 !== 1'b0)    begin bad++; $display("FAIL seq_pll_reset_c4 got=%b want=0", pr4); end
        total++; if (clk_rise != 29)  begin bad++; $display("FAIL seq_clkdiv_rise got=%0d want=29", clk_rise); end
        total++; if (hdmi_rise != 37) begin bad++; $display("FAIL seq_hdmi_rise got=%0d want=37", hdmi_rise); end
        total++; if (rdy_rise != 37)  begin bad++; $display("FAIL seq_ready_rise got=%0d want=37", rdy_rise); end
    endtask

    // No lock: retries at 54/108/162 (4 RST + 50 WAIT each), FAIL at 216.
    task automatic test_timeout_fail();
        int   rises, r1, r2, r3, first_fail, hi_first;
        logic prev, dropped;
        rises = 0; r1 = -1; r2 = -1; r3 = -1; first_fail = -1; hi_first = 0; dropped = 1'b0;
        do_reset(1'b0);
        prev = pll_reset;
        for (int k = 1; k <= 240; k++) begin
            step();
            if (pll_reset === 1'b1 && prev === 1'b0) rises++;
            prev = pll_reset;
            if (k >= 54 && k < 60 && pll_reset === 1'b1) hi_first++;
            if (retry_cnt === 2'd1 && r1 < 0) r1 = k;
            if (retry_cnt === 2'd2 && r2 < 0) r2 = k;
            if (retry_cnt === 2'd3 && r3 < 0) r3 = k;
            if (fail === 1'b1 && first_fail < 0) first_fail = k;
            if (first_fail >= 0 && pll_reset !== 1'b1) dropped = 1'b1;
        end
        total++; if (rises != 4)        begin bad++; $display("FAIL to_pll_reset_rises got=%0d want=4", rises); end
        total++; if (hi_first != 4)     begin bad++; $display("FAIL to_pulse_width got=%0d want=4", hi_first); end
        total++; if (r1 != 54)          begin bad++; $display("FAIL to_retry1 got=%0d want=54", r1); end
        total++; if (r2 != 108)         begin bad++; $display("FAIL to_retry2 got=%0d want=108", r2); end
        total++; if (r3 != 162)         begin bad++; $display("FAIL to_retry3 got=%0d want=162", r3); end
        total++; if (first_fail != 216) begin bad++; $display("FAIL to_fail_cycle got=%0d want=216", first_fail); end
        total++; if (dropped !== 1'b0)  begin bad++; $display("FAIL to_pll_reset_held got=%b want=0", dropped); end
        total++; if (fail !== 1'b1)     begin bad++; $display("FAIL to_fail_end got=%b want=1", fail); end
        total++; if (retry_cnt !== 2'd3) begin bad++; $display("FAIL to_retry_end got=%0d want=3", retry_cnt); end
        total++; if ({clkdiv_resetn, hdmi_rst_n, ready} !== 3'b000)
            begin bad++; $display("FAIL to_downstream got=%b want=000", {clkdiv_resetn, hdmi_rst_n, ready}); end
    endtask

    // One timeout then lock: retry_cnt is 1 until RUN clears it.
    task automatic test_retry_clear();
        bit ok;
        do_reset(1'b0);
        repeat (60) step();
        total++; if (retry_cnt !== 2'd1) begin bad++; $display("FAIL rc_before got=%0d want=1", retry_cnt); end
        pll_lock = 1'b1;
        wait_ready(100, ok);
        total++; if (ok !== 1'b1)        begin bad++; $display("FAIL rc_ready_timeout got=%b want=1", ok); end
        total++; if (retry_cnt !== 2'd0) begin bad++; $display("FAIL rc_after got=%0d want=0", retry_cnt); end
    endtask

    // From RUN: one-cycle lock drop; LOSS 3 cycles later, then a 4-cycle pulse.
    task automatic test_lock_loss();
        bit ok;
        int hi;
        total++; if (relock_cnt !== 8'd0) begin bad++; $display("FAIL ll_relock_pre got=%0d want=0", relock_cnt); end
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        step();
        total++; if ({clkdiv_resetn, hdmi_rst_n} !== 2'b11)
            begin bad++; $display("FAIL ll_before_loss got=%b want=11", {clkdiv_resetn, hdmi_rst_n}); end
        step();
        total++; if ({clkdiv_resetn, hdmi_rst_n, ready} !== 3'b000)
            begin bad++; $display("FAIL ll_fall_together got=%b want=000", {clkdiv_resetn, hdmi_rst_n, ready}); end
        total++; if (relock_cnt !== 8'd1) begin bad++; $display("FAIL ll_relock got=%0d want=1", relock_cnt); end
        total++; if (pll_reset !== 1'b0)  begin bad++; $display("FAIL ll_loss_pll_reset got=%b want=0", pll_reset); end
        hi = 0;
        for (int j = 0; j < 4; j++) begin
            step();
            if (pll_reset === 1'b1) hi++;
        end
        total++; if (hi != 4) begin bad++; $display("FAIL ll_pulse_width got=%0d want=4", hi); end
        step();
        total++; if (pll_reset !== 1'b0) begin bad++; $display("FAIL ll_pulse_end got=%b want=0", pll_reset); end
        wait_ready(60, ok);
        total++; if (ok !== 1'b1)         begin bad++; $display("FAIL ll_relock_timeout got=%b want=1", ok); end
        total++; if (retry_cnt !== 2'd0)  begin bad++; $display("FAIL ll_retry got=%0d want=0", retry_cnt); end
        total++; if (relock_cnt !== 8'd1) begin bad++; $display("FAIL ll_relock_run got=%0d want=1", relock_cnt); end
    endtask

    // Glitch seen at stable count 10 (cycle 16): STABLE restarts at 17, DIV_REL 33, RUN 41.
    task automatic test_stable_glitch();
        int   clk_rise, hdmi_rise;
        logic extra_pulse, retried;
        clk_rise = -1; hdmi_rise = -1; extra_pulse = 1'b0; retried = 1'b0;
        do_reset(1'b1);
        for (int k = 1; k <= 45; k++) begin
            step();
            if (k > 4 && pll_reset === 1'b1) extra_pulse = 1'b1;
            if (retry_cnt !== 2'd0) retried = 1'b1;
            if (clkdiv_resetn === 1'b1 && clk_rise < 0) clk_rise = k;
            if (hdmi_rst_n === 1'b1 && hdmi_rise < 0)   hdmi_rise = k;
            if (k == 13) pll_lock = 1'b0;
            if (k == 14) pll_lock = 1'b1;
        end
        total++; if (clk_rise != 33)       begin bad++; $display("FAIL gl_clkdiv_rise got=%0d want=33", clk_rise); end
        total++; if (hdmi_rise != 41)      begin bad++; $display("FAIL gl_hdmi_rise got=%0d want=41", hdmi_rise); end
        total++; if (extra_pulse !== 1'b0) begin bad++; $display("FAIL gl_no_rst_pulse got=%b want=0", extra_pulse); end
        total++; if (retried !== 1'b0)     begin bad++; $display("FAIL gl_no_retry got=%b want=0", retried); end
    endtask

    // Reset asserted between edges while in DIV_REL (relock_cnt=2 beforehand).
    task automatic test_reset_mid_div_rel();
        bit ok;
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_clkdiv(1'b0, 10, ok);
        total++; if (ok !== 1'b1)         begin bad++; $display("FAIL md_loss_timeout got=%b want=1", ok); end
        total++; if (relock_cnt !== 8'd2) begin bad++; $display("FAIL md_relock got=%0d want=2", relock_cnt); end
        wait_clkdiv(1'b1, 60, ok);
        total++; if (ok !== 1'b1)         begin bad++; $display("FAIL md_divrel_timeout got=%b want=1", ok); end
        step();
        step();
        total++; if ({clkdiv_resetn, hdmi_rst_n} !== 2'b10)
            begin bad++; $display("FAIL md_in_divrel got=%b want=10", {clkdiv_resetn, hdmi_rst_n}); end
        reset = 1'b1;
        #1;
        total++; if ({pll_reset, clkdiv_resetn, hdmi_rst_n, ready, fail} !== 5'b10000)
            begin bad++; $display("FAIL md_async_outputs got=%b want=10000", {pll_reset, clkdiv_resetn, hdmi_rst_n, ready, fail}); end
        total++; if (relock_cnt !== 8'd0) begin bad++; $display("FAIL md_async_relock got=%0d want=0", relock_cnt); end
        total++; if (retry_cnt !== 2'd0)  begin bad++; $display("FAIL md_async_retry got=%0d want=0", retry_cnt); end
        step();
        reset = 1'b0;
        step();
        total++; if ({pll_reset, clkdiv_resetn} !== 2'b10)
            begin bad++; $display("FAIL md_restart got=%b want=10", {pll_reset, clkdiv_resetn}); end
    endtask

    // 260 losses from DIV_REL; count must stick at 255.
    task automatic test_relock_saturation();
        bit         ok;
        logic [7:0] exp;
        do_reset(1'b1);
        for (int i = 0; i < 260; i++) begin
            wait_clkdiv(1'b1, 60, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL sat_divrel_timeout iter=%0d got=%b want=1", i, ok); break; end
            pll_lock = 1'b0;
            step();
            pll_lock = 1'b1;
            wait_clkdiv(1'b0, 10, ok);
            total++; if (ok !== 1'b1) begin bad++; $display("FAIL sat_loss_timeout iter=%0d got=%b want=1", i, ok); break; end
            exp = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
            total++; if (relock_cnt !== exp) begin bad++; $display("FAIL sat_relock iter=%0d got=%0d want=%0d", i, relock_cnt, exp); end
        end
        repeat (5) step();
        total++; if (relock_cnt !== 8'd255) begin bad++; $display("FAIL sat_final got=%0d want=255", relock_cnt); end
    endtask

    initial begin
        test_reset();
        test_lock_sequence();
        test_timeout_fail();
        test_retry_clear();
        test_lock_loss();
        test_reset_mid_div_rel();
        test_stable_glitch();
        test_relock_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
